object_event_tracker: RTL and testbench

Downstream consumer of the debounced `object` level from hm_ir_proximity.
- Detects object arrival and departure.
- Counts arrivals and measures dwell time, i.e. the number of clock cycles the object stays present.
- Hands each completed event to the next stage (display/UART) through a one-entry valid/ready output register.

---
 rtl/object_event_tracker.sv | 132 +++++++++++++
 tb/tb_object_event_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/object_event_tracker.sv
// Tracks arrivals and dwell time of a debounced presence level and hands each completed
// event downstream through a one-entry valid/ready register. Optional: OBJ_TIMEOUT_EN.
module object_event_tracker #(
  parameter int CNT_W   = 8,
  parameter int DW_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             object_i,
  input  logic             clr_i,
  input  logic             evt_ready_i,
  output logic             evt_valid_o,
  output logic [DW_W-1:0]  evt_dwell_o,
  output logic [CNT_W-1:0] obj_count_o,
  output logic             present_o,
  output logic             overflow_o,
  output logic             timeout_o
);

  // Handshake: an event transfers on a clock edge where evt_valid_o && evt_ready_i;
  // evt_dwell_o holds steady while evt_valid_o is high and not yet accepted.

  localparam logic IDLE    = 1'b0;
  localparam logic PRESENT = 1'b1;

  localparam logic [DW_W-1:0] DW_MAX = '1;

  logic             state_q, state_d;
  logic             obj_q;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [DW_W-1:0]  evt_dwell_q, evt_dwell_d;
  logic             ovf_q, ovf_d;
  logic             timeout_q, timeout_d;
  logic             rise;
  logic             done;

  assign rise = object_i & ~obj_q;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    count_d = count_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESENT;
          dwell_d = DW_W'(1);
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        if (object_i) begin
          if (dwell_q != DW_MAX) dwell_d = dwell_q + 1'b1;
        end else begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
    endcase
  end

  // A completed event may replace one that is being consumed on the same edge.
  always_comb begin
    valid_d     = valid_q;
    evt_dwell_d = evt_dwell_q;
    ovf_d       = ovf_q;
    if (done) begin
      if (!valid_q || evt_ready_i) begin
        valid_d     = 1'b1;
        evt_dwell_d = dwell_q;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && evt_ready_i) begin
      valid_d = 1'b0;
    end
  end

`ifdef OBJ_TIMEOUT_EN
  localparam logic [DW_W-1:0] TIMEOUT_V = DW_W'(TIMEOUT);
  // Saturation keeps dwell_q at its value, so the second term blocks re-firing.
  assign timeout_d = (state_d == PRESENT) && (dwell_d == TIMEOUT_V) &&
                     ((state_q == IDLE) || (dwell_q != TIMEOUT_V));
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      obj_q       <= 1'b0;
      dwell_q     <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      evt_dwell_q <= '0;
      ovf_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      obj_q <= object_i;
      if (clr_i) begin
        state_q     <= IDLE;
        dwell_q     <= '0;
        count_q     <= '0;
        valid_q     <= 1'b0;
        evt_dwell_q <= '0;
        ovf_q       <= 1'b0;
        timeout_q   <= 1'b0;
      end else begin
        state_q     <= state_d;
        dwell_q     <= dwell_d;
        count_q     <= count_d;
        valid_q     <= valid_d;
        evt_dwell_q <= evt_dwell_d;
        ovf_q       <= ovf_d;
        timeout_q   <= timeout_d;
      end
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_dwell_o = evt_dwell_q;
  assign obj_count_o = count_q;
  assign present_o   = (state_q == PRESENT);
  assign overflow_o  = ovf_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_object_event_tracker.sv
// Bench for object_event_tracker: directed scenarios plus randomized presence traffic,
// all compared against a pulse-level reference model.
module tb_object_event_tracker;

  localparam int CNT_W   = 2;
  localparam int DW_W    = 4;
  localparam int TIMEOUT = 4;
  localparam int DW_MAX  = (1 << DW_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             object_i;
  logic             clr_i;
  logic             evt_ready_i;
  logic             evt_valid_o;
  logic [DW_W-1:0]  evt_dwell_o;
  logic [CNT_W-1:0] obj_count_o;
  logic             present_o;
  logic             overflow_o;
  logic             timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: presence run length, arrival total, and the output register as a queue.
  bit              m_present;
  bit              m_prev;
  bit              m_ovf;
  bit              m_to;
  int              m_len;
  int              m_count;
  logic [DW_W-1:0] exp_q[$];

  always #10 clk = ~clk;

  object_event_tracker #(
    .CNT_W  (CNT_W),
    .DW_W   (DW_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .object_i   (object_i),
    .clr_i      (clr_i),
    .evt_ready_i(evt_ready_i),
    .evt_valid_o(evt_valid_o),
    .evt_dwell_o(evt_dwell_o),
    .obj_count_o(obj_count_o),
    .present_o  (present_o),
    .overflow_o (overflow_o),
    .timeout_o  (timeout_o)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_present = 1'b0;
    m_prev    = 1'b0;
    m_ovf     = 1'b0;
    m_to      = 1'b0;
    m_len     = 0;
    m_count   = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit obj, input bit clr, input bit rdy);
    bit done;
    done = 1'b0;
    m_to = 1'b0;
    if (clr) begin
      m_present = 1'b0;
      m_len     = 0;
      m_count   = 0;
      m_ovf     = 1'b0;
      exp_q.delete();
    end else begin
      if (!m_present) begin
        if (obj && !m_prev) begin
          m_present = 1'b1;
          m_len     = 1;
          m_count   = (m_count + 1) % (1 << CNT_W);
          m_to      = (m_len == TIMEOUT);
        end
      end else if (obj) begin
        m_len++;
        m_to = (m_len == TIMEOUT);
      end else begin
        m_present = 1'b0;
        done      = 1'b1;
      end
      if (done) begin
        if (exp_q.size() == 0 || rdy) begin
          exp_q.delete();
          exp_q.push_back(DW_W'((m_len > DW_MAX) ? DW_MAX : m_len));
        end else begin
          m_ovf = 1'b1;
        end
      end else if (rdy && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
    m_prev = obj;
`ifndef OBJ_TIMEOUT_EN
    m_to = 1'b0;
`endif
  endtask

  task automatic check_model();
    check_eq("present", int'(present_o), int'(m_present));
    check_eq("count", int'(obj_count_o), m_count);
    check_eq("valid", int'(evt_valid_o), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) check_eq("dwell", int'(evt_dwell_o), int'(exp_q[0]));
    check_eq("overflow", int'(overflow_o), int'(m_ovf));
    check_eq("timeout", int'(timeout_o), int'(m_to));
  endtask

  task automatic cycle(input bit obj, input bit clr, input bit rdy);
    object_i    = obj;
    clr_i       = clr;
    evt_ready_i = rdy;
    @(posedge clk);
    model_step(obj, clr, rdy);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("rst_valid", int'(evt_valid_o), 0);
    check_eq("rst_dwell", int'(evt_dwell_o), 0);
    check_eq("rst_count", int'(obj_count_o), 0);
    check_eq("rst_present", int'(present_o), 0);
    check_eq("rst_overflow", int'(overflow_o), 0);
    check_eq("rst_timeout", int'(timeout_o), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, rdy);
    cycle(1'b0, 1'b0, rdy);
  endtask

  initial begin
    int seq[5];
    int to_cnt;
    int exp_to;
    bit obj;
    seq = '{1, 2, 3, 0, 1};
    rst         = 1'b0;
    object_i    = 1'b0;
    clr_i       = 1'b0;
    evt_ready_i = 1'b0;
    #3;
    do_reset();

    // Single 5-cycle presence, downstream always ready.
    pulse(5, 1'b1);
    check_eq("t1_valid", int'(evt_valid_o), 1);
    check_eq("t1_dwell", int'(evt_dwell_o), 5);
    check_eq("t1_count", int'(obj_count_o), 1);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("t1_drained", int'(evt_valid_o), 0);

    // Three pulses with a stalled consumer: first event held, later ones dropped.
    cycle(1'b0, 1'b1, 1'b0);
    pulse(2, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    pulse(3, 1'b0);
    check_eq("t2_ovf_after_2nd", int'(overflow_o), 1);
    cycle(1'b0, 1'b0, 1'b0);
    pulse(4, 1'b0);
    check_eq("t2_dwell_held", int'(evt_dwell_o), 2);
    check_eq("t2_valid_held", int'(evt_valid_o), 1);
    check_eq("t2_count", int'(obj_count_o), 3);

    // Departure coincides with acceptance of the pending event.
    cycle(1'b0, 1'b1, 1'b0);
    pulse(3, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("t4_valid", int'(evt_valid_o), 1);
    check_eq("t4_dwell", int'(evt_dwell_o), 2);
    check_eq("t4_ovf", int'(overflow_o), 0);
    cycle(1'b0, 1'b0, 1'b1);

    // Arrival counter wrap with a 2-bit counter.
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      check_eq("t5_count_seq", int'(obj_count_o), seq[i]);
      cycle(1'b0, 1'b0, 1'b1);
    end

    // Reset mid-presence, released while the object is still there.
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("t6_present", int'(present_o), 1);
    check_eq("t6_count", int'(obj_count_o), 1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Long presence across the timeout threshold.
    cycle(1'b0, 1'b1, 1'b1);
    to_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      to_cnt += int'(timeout_o);
    end
    cycle(1'b0, 1'b0, 1'b1);
`ifdef OBJ_TIMEOUT_EN
    exp_to = 1;
`else
    exp_to = 0;
`endif
    check_eq("t7_timeout_pulses", to_cnt, exp_to);
    check_eq("t7_dwell", int'(evt_dwell_o), 10);
    check_eq("t7_valid", int'(evt_valid_o), 1);

    // Randomized traffic, including saturation, overflow and occasional clears.
    obj = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) obj = ~obj;
      if ($urandom_range(40) == 0) obj = 1'b1;
      cycle(obj, ($urandom_range(63) == 0), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
